// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
// Receive-side byte FIFO between the UART receiver and the monitor command
// state machine. Each rising edge of the receiver's done level is one
// transaction: bytes flagged bad are counted and discarded, good bytes are
// queued and offered to the consumer first-word-fall-through. The fill level
// drives an active-low clear-to-send line so the sender is throttled before
// the queue runs out of room.

module uart_rx_buffer #(
  parameter int DATA_BITS     = 8,
  parameter int DEPTH         = 16,
  parameter int CTS_THRESHOLD = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_BITS-1:0]     in_data,
  input  logic                     in_done,
  input  logic                     in_error,
  output logic [DATA_BITS-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     cts_n,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               err_count,
  input  logic                     clear_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Constants in the widths they are compared against.
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CTS_C   = CW'(CTS_THRESHOLD);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Storage and bookkeeping state.
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 done_d;

  // Per-cycle decoded events.
  logic                 ev;
  logic                 good_ev;
  logic                 err_ev;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [CW-1:0]        count_next;

  // Decode the capture event and the push/pop/drop decisions for this edge.
  always_comb begin
    ev      = in_done & ~done_d;
    good_ev = ev & ~in_error;
    err_ev  = ev & in_error;
    full    = (count == DEPTH_C);
    pop     = out_valid & out_ready;
    // A pop on a full queue frees the slot the incoming byte needs.
    push    = good_ev & (~full | pop);
    drop    = good_ev & full & ~pop;
  end

  // Post-update fill level, used by both the counter and clear-to-send.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + ONE_C;
      2'b01:   count_next = count - ONE_C;
      default: count_next = count;
    endcase
  end

  // Remember the previous done level; starts high so a level already up at
  // reset release is not mistaken for a new transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_d <= 1'b1;
    end else begin
      done_d <= in_done;
    end
  end

  // Queue pointers and fill count; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
    end
  end

  // Byte storage; contents need no reset because count governs validity.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Clear-to-send follows the fill level after this edge's update.
  always_ff @(posedge clk) begin
    if (reset) begin
      cts_n <= 1'b1;
    end else begin
      cts_n <= (count_next >= CTS_C);
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_flags) begin
      overflow <= 1'b0;
    end
  end

  // Saturating bad-byte counter; an error in the same cycle as a clear
  // leaves the counter at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (err_ev) begin
      if (clear_flags) begin
        err_count <= 8'd1;
      end else if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end else if (clear_flags) begin
      err_count <= 8'd0;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer
// Directed and randomized stimulus for uart_rx_buffer, checked every cycle
// against a queue-based reference model of the receive buffer.

module tb_uart_rx_buffer;

  localparam int DATA_BITS     = 8;
  localparam int DEPTH         = 16;
  localparam int CTS_THRESHOLD = 12;

  logic                   clk;
  logic                   reset;
  logic [DATA_BITS-1:0]   in_data;
  logic                   in_done;
  logic                   in_error;
  logic [DATA_BITS-1:0]   out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   cts_n;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic [7:0]             err_count;
  logic                   clear_flags;

  // Reference model state.
  logic [7:0] m_q[$];
  logic       m_prev_done;
  logic       m_ovf;
  int         m_err;
  logic       m_cts;

  // Bytes the DUT actually handed over, and bytes the bench offered.
  logic [7:0] dut_popped[$];
  logic [7:0] sent[$];

  int checks;
  int fails;

  uart_rx_buffer #(
    .DATA_BITS(DATA_BITS),
    .DEPTH(DEPTH),
    .CTS_THRESHOLD(CTS_THRESHOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_done(in_done),
    .in_error(in_error),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cts_n(cts_n),
    .count(count),
    .overflow(overflow),
    .err_count(err_count),
    .clear_flags(clear_flags)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      checkValue("out_data", 32'(out_data), 32'(m_q[0]));
    end
    checkValue("count", 32'(count), 32'(m_q.size()));
    checkValue("count_bound", 32'(count <= DEPTH), 32'd1);
    checkValue("cts_n", 32'(cts_n), 32'(m_cts));
    checkValue("overflow", 32'(overflow), 32'(m_ovf));
    checkValue("err_count", 32'(err_count), 32'(m_err));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic applyStimulus(input logic rst, input logic done, input logic err,
                               input logic [7:0] data, input logic rdy, input logic clr);
    logic ev;
    logic pop;
    logic full;
    reset       = rst;
    in_done     = done;
    in_error    = err;
    in_data     = data;
    out_ready   = rdy;
    clear_flags = clr;
    if (!rst && rdy && out_valid) begin
      dut_popped.push_back(out_data);
    end
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_prev_done = 1'b1;
      m_ovf       = 1'b0;
      m_err       = 0;
      m_cts       = 1'b1;
    end else begin
      ev          = done && !m_prev_done;
      m_prev_done = done;
      full        = (m_q.size() == DEPTH);
      pop         = rdy && (m_q.size() != 0);
      if (pop) begin
        void'(m_q.pop_front());
      end
      if (ev && err) begin
        m_err = clr ? 1 : ((m_err == 255) ? 255 : m_err + 1);
      end else if (clr) begin
        m_err = 0;
      end
      if (ev && !err && full && !pop) begin
        m_ovf = 1'b1;
      end else begin
        if (clr) m_ovf = 1'b0;
        if (ev && !err) m_q.push_back(data);
      end
      m_cts = (m_q.size() >= CTS_THRESHOLD);
    end
    #1;
    checkOutput();
  endtask

  // One receive transaction: done high for hi cycles, then low for lo cycles.
  task automatic sendByte(input logic [7:0] data, input logic err, input int hi, input int lo);
    for (int i = 0; i < hi; i++) applyStimulus(1'b0, 1'b1, err, data, 1'b0, 1'b0);
    for (int i = 0; i < lo; i++) applyStimulus(1'b0, 1'b0, err, data, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    logic       r;
    int         hi;
    checks      = 0;
    fails       = 0;
    m_prev_done = 1'b1;
    m_ovf       = 1'b0;
    m_err       = 0;
    m_cts       = 1'b1;

    // Reset with in_done already high: must not be captured after release.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    checkValue("cts_after_release", 32'(cts_n), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0);
    checkValue("no_capture_at_release", 32'(count), 32'd0);

    // Three long pulses queue in order; then drain them.
    sendByte(8'hA5, 1'b0, 4, 1);
    sendByte(8'h3C, 1'b0, 4, 1);
    sendByte(8'h81, 1'b0, 4, 1);
    checkValue("three_count", 32'(count), 32'd3);
    checkValue("three_head", 32'(out_data), 32'hA5);
    dut_popped.delete();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkValue("drain_empty", 32'(out_valid), 32'd0);
    checkValue("drain_n", 32'(dut_popped.size()), 32'd3);
    if (dut_popped.size() == 3) begin
      checkValue("drain_0", 32'(dut_popped[0]), 32'hA5);
      checkValue("drain_1", 32'(dut_popped[1]), 32'h3C);
      checkValue("drain_2", 32'(dut_popped[2]), 32'h81);
    end

    // Twelve pushes reach the threshold; one pop releases it.
    for (int i = 0; i < 12; i++) begin
      sendByte(8'(8'h10 + i), 1'b0, 1, 0);
      if (i == 11) checkValue("cts_at_12", 32'(cts_n), 32'd1);
      else         checkValue("cts_below_12", 32'(cts_n), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkValue("cts_after_pop", 32'(cts_n), 32'd0);

    // Fill to sixteen, then overflow on 0x77 while clear_flags is also set.
    for (int i = 0; i < 5; i++) sendByte(8'(8'h40 + i), 1'b0, 1, 1);
    checkValue("full_count", 32'(count), 32'd16);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
    checkValue("ovf_set", 32'(overflow), 32'd1);
    checkValue("ovf_count", 32'(count), 32'd16);

    // Push 0x55 together with a pop on a full queue: accepted, no overflow.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
    checkValue("pushpop_count", 32'(count), 32'd16);
    checkValue("pushpop_ovf_cleared", 32'(overflow), 32'd0);
    dut_popped.delete();
    for (int i = 0; i < 18; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkValue("pushpop_n", 32'(dut_popped.size()), 32'd16);
    if (dut_popped.size() != 0) checkValue("last_is_55", 32'(dut_popped[$]), 32'h55);

    // Error bytes: counted, never queued, saturate at 255, then clear.
    for (int i = 0; i < 3; i++) sendByte(8'hEE, 1'b1, 2, 1);
    checkValue("err3", 32'(err_count), 32'd3);
    checkValue("err3_count", 32'(count), 32'd0);
    for (int i = 0; i < 252; i++) sendByte(8'hEE, 1'b1, 1, 1);
    checkValue("err255", 32'(err_count), 32'd255);
    sendByte(8'hEE, 1'b1, 1, 1);
    checkValue("err_sat", 32'(err_count), 32'd255);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkValue("err_clr", 32'(err_count), 32'd0);
    sendByte(8'hEE, 1'b1, 1, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    checkValue("err_clr_wins", 32'(err_count), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Random stream across pointer wrap with random consumer readiness.
    dut_popped.delete();
    sent.delete();
    for (int n = 0; n < 40; n++) begin
      b  = 8'($urandom);
      hi = $urandom_range(1, 3);
      sent.push_back(b);
      for (int i = 0; i < hi; i++) begin
        r = ($urandom_range(0, 3) != 0);
        applyStimulus(1'b0, 1'b1, 1'b0, b, r, 1'b0);
      end
      for (int i = 0; i < int'($urandom_range(1, 2)); i++) begin
        r = ($urandom_range(0, 3) != 0);
        applyStimulus(1'b0, 1'b0, 1'b0, b, r, 1'b0);
      end
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    if (m_ovf == 1'b0) begin
      checkValue("stream_n", 32'(dut_popped.size()), 32'(sent.size()));
      for (int i = 0; i < sent.size() && i < dut_popped.size(); i++) begin
        checkValue("stream_byte", 32'(dut_popped[i]), 32'(sent[i]));
      end
    end

    // Reset mid-operation flushes the queue.
    sendByte(8'hC1, 1'b0, 1, 1);
    sendByte(8'hC2, 1'b0, 1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkValue("flush_count", 32'(count), 32'd0);
    checkValue("flush_cts", 32'(cts_n), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    sendByte(8'hD7, 1'b0, 1, 1);
    checkValue("after_flush_head", 32'(out_data), 32'hD7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
